// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - CPU DMEM port to multi-cycle req/ack data RAM bridge
//
// Purpose: turns each single-cycle CPU load/store into a req/ack memory
// transaction and stalls the CPU until it completes. Misaligned accesses
// and timed-out accesses raise sticky error flags.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cpu_addr/cpu_wdata/cpu_wena/cpu_rena   CPU DMEM request
//   cpu_rdata, stall                        CPU load data and pipeline freeze
//   mem_req/mem_we/mem_addr/mem_wdata       registered memory request
//   mem_ack/mem_rdata                       memory completion pulse and data
//   err_misalign, err_timeout               sticky error flags
//
// Option: DMEM_BRIDGE_WBUF_EN enables a single-entry posted write buffer.
module dmem_bridge #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_wena,
   input  logic        cpu_rena,
   output logic [31:0] cpu_rdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        err_misalign,
   output logic        err_timeout
);

   localparam int CW_RAW = $clog2(TIMEOUT + 1);
   localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_WB} state_t;

   state_t          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [31:0]     cpu_rdata_q, cpu_rdata_d;
   logic            err_misalign_q, err_misalign_d;
   logic            err_timeout_q, err_timeout_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            access;
   logic            aligned;
   logic [CW-1:0]   cnt_inc;
   logic            timed_out;

   always_comb begin
      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      cpu_rdata_d    = cpu_rdata_q;
      err_misalign_d = err_misalign_q;
      err_timeout_d  = err_timeout_q;
      cnt_d          = cnt_q;
      stall          = 1'b0;

      access    = cpu_rena | cpu_wena;
      aligned   = (cpu_addr[1:0] == 2'b00);
      cnt_inc   = cnt_q + CW'(1);
      // cnt_q counts REQ cycles already spent without ack; this cycle is the next one
      timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

      case (state_q)
         S_IDLE: begin
            if (access) begin
               stall = 1'b1;
               if (!aligned) begin
                  err_misalign_d = 1'b1;
                  cpu_rdata_d    = 32'h0;
                  state_d        = S_DONE;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = cpu_wena;
                  mem_addr_d  = {cpu_addr[31:2], 2'b00};
                  mem_wdata_d = cpu_wdata;
                  cnt_d       = '0;
                  state_d     = S_REQ;
`ifdef DMEM_BRIDGE_WBUF_EN
                  // store is posted: CPU moves on while the buffer drains
                  if (cpu_wena) begin
                     stall   = 1'b0;
                     state_d = S_WB;
                  end
`endif
               end
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) cpu_rdata_d = mem_rdata;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_inc;
               if (timed_out) begin
                  mem_req_d     = 1'b0;
                  err_timeout_d = 1'b1;
                  if (!mem_we_q) cpu_rdata_d = ERR_DATA;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // CPU captures cpu_rdata at this edge; the access it still shows is not reissued
            state_d = S_IDLE;
         end
`ifdef DMEM_BRIDGE_WBUF_EN
         S_WB: begin
            // any new access waits for the buffered store to drain
            stall = access;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (timed_out) begin
                  mem_req_d     = 1'b0;
                  err_timeout_d = 1'b1;
                  state_d       = S_IDLE;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 32'h0;
         mem_wdata_q    <= 32'h0;
         cpu_rdata_q    <= 32'h0;
         err_misalign_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         cpu_rdata_q    <= cpu_rdata_d;
         err_misalign_q <= err_misalign_d;
         err_timeout_q  <= err_timeout_d;
         cnt_q          <= cnt_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_rdata    = cpu_rdata_q;
   assign err_misalign = err_misalign_q;
   assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - self-checking bench for dmem_bridge
module tb_dmem_bridge;

   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef DMEM_BRIDGE_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_wena = 1'b0;
   logic        cpu_rena = 1'b0;
   logic [31:0] cpu_rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        err_misalign;
   logic        err_timeout;

   dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wena(cpu_wena), .cpu_rena(cpu_rena),
      .cpu_rdata(cpu_rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference state: what the CPU should see after each completed access
   logic [31:0] m_rdata = '0;
   logic        m_mis   = 1'b0;
   logic        m_to    = 1'b0;
   logic [31:0] mem_m [logic [29:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [29:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   // One CPU access from IDLE; the bench answers as the memory, acking on the
   // delay-th request cycle (0 = never). Called and returns on a negedge.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int delay, input logic [31:0] rv_force, input bit use_force);
      int          stalls = 0;
      int          reqs   = 0;
      bit          done   = 0;
      bit          mis;
      int          exp_stalls;
      logic [31:0] rv;
      mis = (addr[1:0] != 2'b00);
      rv  = use_force ? rv_force : mem_rd(addr[31:2]);
      cpu_wena  = we;
      cpu_rena  = !we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         mem_ack = 1'b0;
         #1;
         if (mem_req) begin
            reqs++;
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("mem_we", {31'b0, mem_we}, {31'b0, we});
            if (we) check("mem_wdata", mem_wdata, wd);
            if (reqs == delay) begin
               mem_ack   = 1'b1;
               mem_rdata = rv;
            end else begin
               mem_rdata = $urandom;
            end
         end
         if (stall) stalls++;
         else done = 1;
         if (!done) @(negedge clk);
      end
      check("access_completes", {31'b0, done}, 32'd1);

      if (mis) begin
         exp_stalls = 1;
         m_mis      = 1'b1;
         m_rdata    = 32'h0;
      end else if (delay >= 1 && delay <= TO) begin
         exp_stalls = delay + 1;
         if (we) mem_m[addr[31:2]] = wd;
         else    m_rdata = rv;
      end else begin
         exp_stalls = TO + 1;
         m_to       = 1'b1;
         if (!we) m_rdata = ERR;
      end

      check("stall_cycles", stalls, exp_stalls);
      check("req_cycles", reqs, exp_stalls - 1);
      check("done_cpu_rdata", cpu_rdata, m_rdata);
      check("done_mem_req", {31'b0, mem_req}, 32'd0);
      check("err_misalign", {31'b0, err_misalign}, {31'b0, m_mis});
      check("err_timeout", {31'b0, err_timeout}, {31'b0, m_to});
      @(negedge clk);
      cpu_wena = 1'b0;
      cpu_rena = 1'b0;
      mem_ack  = 1'b0;
   endtask

   // a stray ack with no access outstanding must change nothing
   task automatic idle_ack();
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      #1;
      check("idle_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("idle_mem_req", {31'b0, mem_req}, 32'd0);
      check("idle_cpu_rdata", cpu_rdata, m_rdata);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic        w;
      int          d;

      #1 rst = 1'b0;
      #1;
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_err_mis", {31'b0, err_misalign}, 32'd0);
      check("rst_err_to", {31'b0, err_timeout}, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // load, ack on second request cycle
      access(1'b0, 32'h10, 32'h0, 2, 32'h12345678, 1'b1);
      // back-to-back load at the minimum latency, and ack exactly at the timeout cycle
      access(1'b0, 32'h14, 32'h0, 1, 32'h0, 1'b0);
      access(1'b0, 32'h18, 32'h0, TO, 32'h0, 1'b0);
      if (!WBUF) access(1'b1, 32'h20, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
      // misaligned load
      access(1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b0);
      idle_ack();
      // load never acked
      access(1'b0, 32'h30, 32'h0, 0, 32'h0, 1'b0);
      if (!WBUF) access(1'b1, 32'h34, 32'h11112222, 0, 32'h0, 1'b0);

      // reset in the middle of a request
      cpu_rena = 1'b1;
      cpu_addr = 32'h40;
      @(negedge clk);
      #1;
      check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("async_rst_err_to", {31'b0, err_timeout}, 32'd0);
      check("async_rst_cpu_rdata", cpu_rdata, 32'd0);
      cpu_rena = 1'b0;
      m_rdata  = 32'h0;
      m_mis    = 1'b0;
      m_to     = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      access(1'b0, 32'h40, 32'h0, 3, 32'h0, 1'b0);

`ifdef DMEM_BRIDGE_WBUF_EN
      // posted store followed immediately by a load
      cpu_wena  = 1'b1;
      cpu_addr  = 32'h80;
      cpu_wdata = 32'hCAFEF00D;
      #1;
      check("wb_store_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      cpu_wena = 1'b0;
      cpu_rena = 1'b1;
      cpu_addr = 32'h84;
      #1;
      check("wb_mem_req", {31'b0, mem_req}, 32'd1);
      check("wb_mem_we", {31'b0, mem_we}, 32'd1);
      check("wb_mem_wdata", mem_wdata, 32'hCAFEF00D);
      check("wb_load_stall", {31'b0, stall}, 32'd1);
      @(negedge clk);
      #1;
      check("wb_load_stall2", {31'b0, stall}, 32'd1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_m[30'h20] = 32'hCAFEF00D;
      access(1'b0, 32'h84, 32'h0, 1, 32'h0, 1'b0);
      access(1'b0, 32'h80, 32'h0, 1, 32'h0, 1'b0);
`endif

      for (int i = 0; i < 30; i++) begin
         a = 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         w = WBUF ? 1'b0 : 1'($urandom_range(0, 1));
         d = $urandom_range(0, 5);
         access(w, a, $urandom, d, 32'h0, 1'b0);
         if ($urandom_range(0, 3) == 0) idle_ack();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
